// File: rtl/sgbm_disp_stream_packer_pkg.sv
// Shared types, default geometry and helpers for the SGBM disparity stream packer.
package sgbm_pkg;

    localparam int COORD_W_DEF = 10;
    localparam int IMG_W_DEF   = 640;
    localparam int IMG_H_DEF   = 480;

    // SYNC: waiting for a frame origin pixel; RUN: tracking raster order.
    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Unsigned clamp of a value to out_w bits (all-ones when it does not fit).
    function automatic logic [63:0] saturate(input logic [63:0] value, input int unsigned out_w);
        logic [63:0] max_val;
        max_val = (64'd1 << out_w) - 64'd1;
        return (value > max_val) ? max_val : value;
    endfunction

endpackage

// File: rtl/sgbm_disp_stream_packer_if.sv
// AXI4-Stream style output bundle of the disparity packer (tdata/tvalid/tready/tlast/tuser).
interface sgbm_disp_stream_packer_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] m_tdata;
    logic              m_tvalid;
    logic              m_tready;
    logic              m_tlast;
    logic              m_tuser;

    modport master (
        output m_tdata, m_tvalid, m_tlast, m_tuser,
        input  m_tready
    );

    modport slave (
        input  m_tdata, m_tvalid, m_tlast, m_tuser,
        output m_tready
    );
endinterface

// File: rtl/sgbm_disp_stream_packer_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module sgbm_sync_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == FULL_COUNT);
    assign level    = count;
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    // Head word is driven straight out; zero when empty so idle outputs read 0.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Storage write.
    // NOTE: the data array has no reset; only pointers/count need one, and leaving it out keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sgbm_disp_stream_packer.sv
// Packs the free-running SGBM disparity stream into saturated multi-pixel beats with SOF/EOL,
// checking raster order and buffering through a FIFO since the source cannot be stalled.
module sgbm_disp_stream_packer
    import sgbm_pkg::*;
#(
    parameter int DISP_W     = 32,
    parameter int OUT_W      = 8,
    parameter int PACK       = 4,
    parameter int IMG_W      = IMG_W_DEF,
    parameter int IMG_H      = IMG_H_DEF,
    parameter int COORD_W    = COORD_W_DEF,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clkin,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          err_clr,
    input  logic [DISP_W-1:0]             disp_in,
    input  logic [COORD_W-1:0]            row_in,
    input  logic [COORD_W-1:0]            col_in,
    input  logic                          valid_in,
    sgbm_disp_stream_packer_if.master     m,
    output logic [15:0]                   frame_cnt,
    output logic                          err_ovf,
    output logic                          err_seq,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int BEAT_W = PACK * OUT_W;
    localparam int FIFO_W = BEAT_W + 2;
    localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
    localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(IMG_H - 1);
    localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(IMG_W - 1);

    state_t                      state;
    logic [COORD_W-1:0]          exp_row;
    logic [COORD_W-1:0]          exp_col;
    logic [PACK-1:0][OUT_W-1:0]  lanes;
    logic                        sof_pending;
    logic                        beat_valid;
    logic [FIFO_W-1:0]           beat_word;

    logic [OUT_W-1:0]            pixel;
    logic                        in_range;
    logic                        at_origin;
    logic                        at_expected;
    logic                        take;
    logic                        seq_evt;
    logic [LANE_W-1:0]           lane_sel;
    logic                        beat_done;
    logic                        frame_done;
    logic [PACK-1:0][OUT_W-1:0]  beat_next;

    logic [FIFO_W-1:0]           fifo_out;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        pop;
    logic                        ovf_evt;

    // Per-pixel decode: saturation, raster check and whether the pixel is taken into the pack register.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        pixel       = OUT_W'(saturate(64'(disp_in), OUT_W));
        in_range    = (row_in <= LAST_ROW) && (col_in <= LAST_COL);
        at_origin   = (row_in == '0) && (col_in == '0);
        at_expected = (row_in == exp_row) && (col_in == exp_col);
        take        = 1'b0;
        if (valid_in) begin
            if (state == RUN && at_expected) begin
                take = 1'b1;
            end else if (at_origin && enable) begin
                take = 1'b1;
            end
        end
        seq_evt    = valid_in && (!in_range || (state == RUN && !at_expected));
        lane_sel   = LANE_W'(col_in % COORD_W'(PACK));
        beat_done  = take && (lane_sel == LANE_W'(PACK - 1));
        frame_done = take && (row_in == LAST_ROW) && (col_in == LAST_COL);
        beat_next            = lanes;
        beat_next[PACK-1]    = pixel;
    end

    // Framing FSM: expected coordinate, pack register, staged beat and frame counter.
    // NOTE: state registers use non-blocking assignments so every branch reads pre-edge values.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SYNC;
            exp_row     <= '0;
            exp_col     <= '0;
            lanes       <= '0;
            sof_pending <= 1'b0;
            beat_valid  <= 1'b0;
            beat_word   <= '0;
            frame_cnt   <= '0;
        end else begin
            beat_valid <= 1'b0;
            if (take) begin
                lanes[lane_sel] <= pixel;
                if (beat_done) begin
                    beat_valid  <= 1'b1;
                    beat_word   <= {at_origin | sof_pending, col_in == LAST_COL, beat_next};
                    sof_pending <= 1'b0;
                end else begin
                    sof_pending <= at_origin | sof_pending;
                end
                if (frame_done) begin
                    exp_row   <= '0;
                    exp_col   <= '0;
                    frame_cnt <= frame_cnt + 16'd1;
                    state     <= enable ? RUN : SYNC;
                end else if (col_in == LAST_COL) begin
                    exp_row <= row_in + 1'b1;
                    exp_col <= '0;
                    state   <= RUN;
                end else begin
                    exp_row <= row_in;
                    exp_col <= col_in + 1'b1;
                    state   <= RUN;
                end
            end else if (valid_in && state == RUN) begin
                // Order broken and no new frame start: drop the partial beat and hunt for (0,0).
                state       <= SYNC;
                exp_row     <= '0;
                exp_col     <= '0;
                sof_pending <= 1'b0;
            end
        end
    end

    assign pop     = m.m_tvalid && m.m_tready;
    assign ovf_evt = beat_valid && fifo_full && !pop;

    // Sticky error flags; a new event outranks a simultaneous clear.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            err_seq <= 1'b0;
            err_ovf <= 1'b0;
        end else begin
            if (seq_evt) begin
                err_seq <= 1'b1;
            end else if (err_clr) begin
                err_seq <= 1'b0;
            end
            if (ovf_evt) begin
                err_ovf <= 1'b1;
            end else if (err_clr) begin
                err_ovf <= 1'b0;
            end
        end
    end

    sgbm_sync_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clkin),
        .rst_n     (rst_n),
        .push      (beat_valid),
        .push_data (beat_word),
        .pop       (pop),
        .pop_data  (fifo_out),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign m.m_tvalid = !fifo_empty;
    assign m.m_tdata  = fifo_out[BEAT_W-1:0];
    assign m.m_tlast  = fifo_out[BEAT_W];
    assign m.m_tuser  = fifo_out[BEAT_W+1];

endmodule
